// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous ROM and presents
// PC/instruction/valid to IF/ID, with stall, squashing redirect, HALT and an accept counter.
module if_fetch_unit #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [11:0] redirect_pc,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [11:0] IF_PC,
  output logic [31:0] IF_Instruction,
  output logic        IF_Valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  // Handshake: IF/ID accepts the presented word on a rising edge where IF_Valid=1 and
  // stall=0 (stall acts as the inverted ready); redirect squashes it before acceptance.
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [11:0] target_pc;
  logic        unused_low_bits;

  assign target_pc       = {redirect_pc[11:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      resp_valid_q  <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      resp_valid_q  <= resp_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    resp_valid_d  = resp_valid_q;
    fetch_count_d = fetch_count_q;
    if (state_q == RUN) begin
      if (redirect) begin
        resp_pc_d    = target_pc;
        pc_d         = target_pc + 12'd4;
        resp_valid_d = 1'b1;
      end else if (stall) begin
        resp_valid_d = resp_valid_q;
      end else if (IF_Valid && (IF_Instruction[31:26] == HALT_OPCODE)) begin
        state_d      = HALTED;
        resp_valid_d = 1'b0;
      end else begin
        resp_pc_d    = pc_q;
        pc_d         = pc_q + 12'd4;
        resp_valid_d = 1'b1;
      end
      if (IF_Valid && !stall && (fetch_count_q != 16'hFFFF)) begin
        fetch_count_d = fetch_count_q + 16'd1;
      end
    end
  end

  always_comb begin
    IF_Valid       = resp_valid_q && !redirect && (state_q == RUN);
    IF_Instruction = IF_Valid ? imem_rdata : NOP_INSTR;
    IF_PC          = resp_pc_q;
    halted         = (state_q == HALTED);
    fetch_count    = fetch_count_q;
    // Stall and HALTED re-read the held word so imem_rdata stays stable.
    if (state_q == HALTED)  imem_addr = resp_pc_q[11:2];
    else if (redirect)      imem_addr = redirect_pc[11:2];
    else if (stall)         imem_addr = resp_pc_q[11:2];
    else                    imem_addr = pc_q[11:2];
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle expected outputs are queued by the driver
// and popped by a negedge monitor that compares them against the DUT.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [11:0] IF_PC;
  logic [31:0] IF_Instruction;
  logic        IF_Valid;
  logic        halted;
  logic [15:0] fetch_count;

  localparam int W = 1 + 12 + 32 + 1 + 16;

  logic [W-1:0] exp_q[$];
  logic [31:0]  rom[1024];
  int           n_checks;
  int           n_errors;
  int           step_no;

  if_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .IF_PC          (IF_PC),
    .IF_Instruction (IF_Instruction),
    .IF_Valid       (IF_Valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Clock / reset and synchronous ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  // Driver: apply this cycle's inputs and queue what the outputs must be in this cycle
  task automatic step(input logic rn, input logic st, input logic rd, input logic [11:0] rpc,
                      input logic ev, input logic [11:0] epc, input logic [31:0] ein,
                      input logic eh, input logic [15:0] ecnt);
    rst_n       = rn;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    exp_q.push_back({ev, epc, ein, eh, ecnt});
    @(posedge clk);
    #1;
    step_no++;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {IF_Valid, IF_PC, IF_Instruction, halted, fetch_count};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL step%0d: got valid=%b pc=%h instr=%h halted=%b count=%0d, expected valid=%b pc=%h instr=%h halted=%b count=%0d",
                 step_no, a[W-1], a[W-2 -: 12], a[W-14 -: 32], a[16], a[15:0],
                 e[W-1], e[W-2 -: 12], e[W-14 -: 32], e[16], e[15:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    step_no  = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + 32'(i);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 12'h000;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then free run
    step(0,0,0,12'h000, 0,12'h000,32'h0,0,16'd0);
    step(1,0,0,12'h000, 0,12'h000,32'h0,0,16'd0);
    step(1,0,0,12'h000, 1,12'h000,32'h1000_0000,0,16'd0);
    step(1,0,0,12'h000, 1,12'h004,32'h1000_0001,0,16'd1);
    step(1,0,0,12'h000, 1,12'h008,32'h1000_0002,0,16'd2);
    step(1,0,0,12'h000, 1,12'h00C,32'h1000_0003,0,16'd3);
    step(1,0,0,12'h000, 1,12'h010,32'h1000_0004,0,16'd4);

    // Reset mid-run, then a 3-cycle stall on 0x008
    step(0,0,0,12'h000, 1,12'h014,32'h1000_0005,0,16'd5);
    step(1,0,0,12'h000, 0,12'h000,32'h0,0,16'd0);
    step(1,0,0,12'h000, 1,12'h000,32'h1000_0000,0,16'd0);
    step(1,0,0,12'h000, 1,12'h004,32'h1000_0001,0,16'd1);
    step(1,1,0,12'h000, 1,12'h008,32'h1000_0002,0,16'd2);
    step(1,1,0,12'h000, 1,12'h008,32'h1000_0002,0,16'd2);
    step(1,1,0,12'h000, 1,12'h008,32'h1000_0002,0,16'd2);
    step(1,0,0,12'h000, 1,12'h008,32'h1000_0002,0,16'd2);
    step(1,0,0,12'h000, 1,12'h00C,32'h1000_0003,0,16'd3);

    // Redirect with simultaneous stall, target low bits ignored
    step(1,1,1,12'h103, 0,12'h010,32'h0,0,16'd4);
    step(1,0,0,12'h000, 1,12'h100,32'h1000_0040,0,16'd4);
    step(1,0,0,12'h000, 1,12'h104,32'h1000_0041,0,16'd5);

    // Wrap from 0xFFC to 0x000
    step(1,0,1,12'hFFC, 0,12'h108,32'h0,0,16'd6);
    step(1,0,0,12'h000, 1,12'hFFC,32'h1000_03FF,0,16'd6);
    step(1,0,0,12'h000, 1,12'h000,32'h1000_0000,0,16'd7);
    step(1,0,0,12'h000, 1,12'h004,32'h1000_0001,0,16'd8);
    step(1,0,0,12'h000, 1,12'h008,32'h1000_0002,0,16'd9);
    step(1,0,0,12'h000, 1,12'h00C,32'h1000_0003,0,16'd10);
    step(1,0,0,12'h000, 1,12'h010,32'h1000_0004,0,16'd11);
    step(1,0,0,12'h000, 1,12'h014,32'h1000_0005,0,16'd12);
    step(1,0,0,12'h000, 1,12'h018,32'h1000_0006,0,16'd13);
    step(1,0,0,12'h000, 1,12'h01C,32'h1000_0007,0,16'd14);

    // Reset asserted during a stall at 0x020
    step(1,1,0,12'h000, 1,12'h020,32'h1000_0008,0,16'd15);
    step(0,1,0,12'h000, 1,12'h020,32'h1000_0008,0,16'd15);
    step(1,0,0,12'h000, 0,12'h000,32'h0,0,16'd0);
    step(1,0,0,12'h000, 1,12'h000,32'h1000_0000,0,16'd0);

    // HALT at 0x00C: counted, then sticky until reset
    rom[3] = 32'hFC00_0000;
    step(1,0,0,12'h000, 1,12'h004,32'h1000_0001,0,16'd1);
    step(1,0,0,12'h000, 1,12'h008,32'h1000_0002,0,16'd2);
    step(1,0,0,12'h000, 1,12'h00C,32'hFC00_0000,0,16'd3);
    step(1,0,1,12'h100, 0,12'h00C,32'h0,1,16'd4);
    step(1,1,0,12'h000, 0,12'h00C,32'h0,1,16'd4);
    step(1,0,0,12'h000, 0,12'h00C,32'h0,1,16'd4);
    step(0,0,0,12'h000, 0,12'h00C,32'h0,1,16'd4);
    step(1,0,0,12'h000, 0,12'h000,32'h0,0,16'd0);
    step(1,0,0,12'h000, 1,12'h000,32'h1000_0000,0,16'd0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the SIMD AES pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, drives the synchronous instruction ROM, and presents `IF_PC` / `IF_Instruction` / `IF_Valid` to IF/ID. Handles pipeline stall, branch redirect with squash, a terminal HALT state, and a count of accepted instructions.

## Interface
Parameters:
- `RESET_PC`, 12'h000, fetch address after reset
- `NOP_INSTR`, 32'h0000_0000, instruction emitted when output is not valid
- `HALT_OPCODE`, 6'h3F, value of `Instruction[31:26]` that halts fetch

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  synchronous, active-low reset
- `stall`  in  1  hazard unit holds IF; same cycle IF/ID is not written
- `redirect`  in  1  taken branch/jump; overrides `stall`
- `redirect_pc`  in  12  branch target byte address; bits [1:0] ignored
- `imem_addr`  out  10  ROM word address; ROM returns data one cycle later
- `imem_rdata`  in  32  ROM read data for previous cycle's `imem_addr`
- `IF_PC`  out  12  byte PC of presented instruction
- `IF_Instruction`  out  32  presented instruction
- `IF_Valid`  out  1  presented instruction is real, not a bubble
- `halted`  out  1  fetch stopped by HALT
- `fetch_count`  out  16  instructions accepted by IF/ID, saturating

## Operation
- Registers: `pc` (next fetch address), `resp_pc` (address of the word now on `imem_rdata`), `resp_valid`, `state` ∈ {RUN, HALTED}, `fetch_count`.
- Reset (`rst_n`=0 at edge): `pc`=`RESET_PC`, `resp_pc`=`RESET_PC`, `resp_valid`=0, `state`=RUN, `fetch_count`=0. Outputs after reset: `IF_Valid`=0, `IF_Instruction`=`NOP_INSTR`, `IF_PC`=`RESET_PC`, `halted`=0. Reset has priority over every other input, including mid-stall or in HALTED.
- Address mux (combinational): redirect → `redirect_pc[11:2]`; else stall → `resp_pc[11:2]` (re-read held word so `imem_rdata` stays stable); else `pc[11:2]`. In HALTED: `resp_pc[11:2]`.
- Outputs: `IF_PC`=`resp_pc`; `IF_Valid`=`resp_valid` && !`redirect` && state==RUN; `IF_Instruction`=`IF_Valid` ? `imem_rdata` : `NOP_INSTR`.
- RUN edge priority:
  - redirect: `resp_pc`←{`redirect_pc[11:2]`,2'b00}, `pc`←that+4, `resp_valid`←1. Instruction presented in the redirect cycle is squashed (bubble enters IF/ID).
  - else stall: `pc`, `resp_pc`, `resp_valid` hold.
  - else if `IF_Valid` and `IF_Instruction[31:26]`==`HALT_OPCODE`: state←HALTED, `resp_valid`←0 (HALT itself is accepted and counted).
  - else: `resp_pc`←`pc`, `pc`←`pc`+4, `resp_valid`←1.
- HALTED: all registers hold, `redirect`/`stall` ignored, `halted`=1; exit only by reset.
- PC arithmetic modulo 2^12: 12'hFFC + 4 = 12'h000, no flag.
- `fetch_count` increments when `IF_Valid`=1 and `stall`=0 and `redirect`=0 at the edge; saturates at 16'hFFFF.

## Timing
- ROM latency 1 cycle; fetch-to-present latency 1 cycle.
- First cycle after reset release: `imem_addr`=`RESET_PC`>>2, `IF_Valid`=0. Next cycle: `IF_Valid`=1, `IF_PC`=`RESET_PC`.
- Steady state: one instruction per cycle, `IF_PC` increments by 4 each cycle.
- Stall of N cycles: outputs identical for N+1 cycles (the stalled cycles plus the releasing cycle); no instruction lost or duplicated into IF/ID.
- Redirect: 1-cycle bubble; target instruction presented the cycle after `redirect`=1.
- Redirect and stall in same cycle: redirect wins.
- HALT: `halted`=1 the cycle after HALT is presented; `IF_Valid`=0 thereafter.

## Test plan
- Reset then free run, ROM[i]=32'h1000_0000+i -> cycle 1 after release `IF_Valid`=0; cycles 2..5 present PC 0x000,0x004,0x008,0x00C with 32'h1000_0000..0003; `fetch_count`=4 after cycle 5.
- Stall held 3 cycles while PC 0x008 presented -> `IF_PC`=0x008, `IF_Instruction`=32'h1000_0002 for 4 cycles, then 0x00C; `fetch_count` increments once for 0x008.
- Redirect to 12'h103 while 0x010 presented, `stall`=1 same cycle -> that cycle `IF_Valid`=0, `IF_Instruction`=0; next cycle `IF_PC`=0x100, then 0x104.
- Wrap: redirect to 0xFFC -> presents 0xFFC then 0x000.
- ROM[0x0C/4]=32'hFC00_0000 -> HALT presented at 0x00C with `IF_Valid`=1, next cycle `halted`=1, `IF_Valid`=0 indefinitely; redirect ignored; `rst_n`=0 restarts at 0x000.
- Reset asserted during a stall at PC 0x020 -> next cycle `IF_Valid`=0, `fetch_count`=0, fetch restarts from `RESET_PC`.
